// File: rtl/maze_solver_if.sv
// Maze memory bus: the solver addresses one cell per cycle and either reads
// its wall/visited bit combinationally or writes a visited mark on the clock.
interface maze_solver_if;
  logic [3:0] X;
  logic [3:0] Y;
  logic       RD;
  logic       WR;
  logic       D_in;
  logic       D_out;

  modport master (
    output X,
    output Y,
    output RD,
    output WR,
    output D_in,
    input  D_out
  );

  modport slave (
    input  X,
    input  Y,
    input  RD,
    input  WR,
    input  D_in,
    output D_out
  );
endinterface

// File: rtl/maze_solver.sv
// Depth-first maze solver. Walks the 16x16 maze memory from START to GOAL,
// marking every entered cell as visited and keeping the current path on an
// internal stack that can be read back by index once the goal is found.
module maze_solver #(
  parameter logic [3:0] START_X = 4'd0,
  parameter logic [3:0] START_Y = 4'd0,
  parameter logic [3:0] GOAL_X  = 4'd15,
  parameter logic [3:0] GOAL_Y  = 4'd15
) (
  input  logic                clk,
  input  logic                rst_n,
  maze_solver_if.master       mem,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [8:0]          path_len,
  input  logic [7:0]          path_idx,
  output logic [3:0]          path_x,
  output logic [3:0]          path_y
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MARK,
    S_CHECK,
    S_BACK,
    S_DONE,
    S_FAIL
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] cur_x_reg, cur_x_next;
  logic [3:0] cur_y_reg, cur_y_next;
  logic [1:0] dir_reg, dir_next;
  logic [8:0] sp_reg, sp_next;
  logic       push_en;

  // Path stack entries are {x, y}; read asynchronously for backtracking and
  // for the combinational path readout.
  logic [7:0] stack_mem [0:255];
  logic [7:0] bt_addr;
  logic [7:0] bt_entry;
  logic [7:0] rd_entry;

  logic [3:0] nb_x;
  logic [3:0] nb_y;
  logic       nb_oob;

  assign bt_addr  = sp_reg[7:0] - 8'd2;
  assign bt_entry = stack_mem[bt_addr];
  assign rd_entry = stack_mem[path_idx];
  assign path_x   = rd_entry[7:4];
  assign path_y   = rd_entry[3:0];

  // Neighbor of the current cell in the direction being tried; edges of the
  // grid are flagged rather than wrapped so the address never aliases.
  always_comb begin
    nb_x   = cur_x_reg;
    nb_y   = cur_y_reg;
    nb_oob = 1'b0;
    case (dir_reg)
      2'd0: if (cur_x_reg == 4'd15) nb_oob = 1'b1; else nb_x = cur_x_reg + 4'd1;
      2'd1: if (cur_y_reg == 4'd15) nb_oob = 1'b1; else nb_y = cur_y_reg + 4'd1;
      2'd2: if (cur_x_reg == 4'd0)  nb_oob = 1'b1; else nb_x = cur_x_reg - 4'd1;
      default: if (cur_y_reg == 4'd0) nb_oob = 1'b1; else nb_y = cur_y_reg - 4'd1;
    endcase
  end

  // State and search-position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cur_x_reg <= 4'd0;
      cur_y_reg <= 4'd0;
      dir_reg   <= 2'd0;
      sp_reg    <= 9'd0;
    end else begin
      state_reg <= state_next;
      cur_x_reg <= cur_x_next;
      cur_y_reg <= cur_y_next;
      dir_reg   <= dir_next;
      sp_reg    <= sp_next;
    end
  end

  // Push the current cell when it is marked; storage needs no reset since
  // only entries below sp are ever meaningful.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[sp_reg[7:0]] <= {cur_x_reg, cur_y_reg};
    end
  end

  // Next-state logic and memory-bus drive for the search.
  always_comb begin
    state_next = state_reg;
    cur_x_next = cur_x_reg;
    cur_y_next = cur_y_reg;
    dir_next   = dir_reg;
    sp_next    = sp_reg;
    push_en    = 1'b0;
    mem.X      = 4'd0;
    mem.Y      = 4'd0;
    mem.RD     = 1'b0;
    mem.WR     = 1'b0;
    mem.D_in   = 1'b0;

    case (state_reg)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          cur_x_next = START_X;
          cur_y_next = START_Y;
          sp_next    = 9'd0;
          state_next = S_INIT;
        end
      end

      S_INIT: begin
        mem.X  = cur_x_reg;
        mem.Y  = cur_y_reg;
        mem.RD = 1'b1;
        state_next = mem.D_out ? S_FAIL : S_MARK;
      end

      S_MARK: begin
        mem.X    = cur_x_reg;
        mem.Y    = cur_y_reg;
        mem.WR   = 1'b1;
        mem.D_in = 1'b1;
        push_en  = 1'b1;
        sp_next  = sp_reg + 9'd1;
        if (cur_x_reg == GOAL_X && cur_y_reg == GOAL_Y) begin
          state_next = S_DONE;
        end else begin
          dir_next   = 2'd0;
          state_next = S_CHECK;
        end
      end

      S_CHECK: begin
        if (!nb_oob) begin
          mem.X  = nb_x;
          mem.Y  = nb_y;
          mem.RD = 1'b1;
        end
        if (!nb_oob && !mem.D_out) begin
          cur_x_next = nb_x;
          cur_y_next = nb_y;
          state_next = S_MARK;
        end else if (dir_reg != 2'd3) begin
          dir_next = dir_reg + 2'd1;
        end else begin
          state_next = S_BACK;
        end
      end

      S_BACK: begin
        // Returning to the previous cell restarts at dir 0: every neighbor
        // already tried is marked and simply reads back as blocked.
        if (sp_reg == 9'd1) begin
          state_next = S_FAIL;
        end else begin
          sp_next    = sp_reg - 9'd1;
          cur_x_next = bt_entry[7:4];
          cur_y_next = bt_entry[3:0];
          dir_next   = 2'd0;
          state_next = S_CHECK;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy     = (state_reg == S_INIT) || (state_reg == S_MARK) ||
               (state_reg == S_CHECK) || (state_reg == S_BACK);
    done     = (state_reg == S_DONE);
    fail     = (state_reg == S_FAIL);
    path_len = (state_reg == S_DONE) ? sp_reg : 9'd0;
  end

endmodule

// File: tb/tb_maze_solver.sv
// Directed testbench for maze_solver: a behavioral 16x16 maze memory, a set
// of hand-analysed mazes, and a second instance with start equal to goal.
module tb_maze_solver;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy, done, fail;
  logic [8:0] path_len;
  logic [7:0] path_idx;
  logic [3:0] path_x, path_y;

  logic       start2;
  logic       busy2, done2, fail2;
  logic [8:0] path_len2;
  logic [7:0] path_idx2;
  logic [3:0] path_x2, path_y2;

  maze_solver_if bus ();
  maze_solver_if bus2 ();

  logic mem  [0:255];
  logic mem2 [0:255];

  int n_checks;
  int n_errors;
  int overlap_cnt;
  int din_bad_cnt;

  maze_solver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem      (bus),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .path_len (path_len),
    .path_idx (path_idx),
    .path_x   (path_x),
    .path_y   (path_y)
  );

  maze_solver #(
    .START_X (4'd5),
    .START_Y (4'd5),
    .GOAL_X  (4'd5),
    .GOAL_Y  (4'd5)
  ) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem      (bus2),
    .start    (start2),
    .busy     (busy2),
    .done     (done2),
    .fail     (fail2),
    .path_len (path_len2),
    .path_idx (path_idx2),
    .path_x   (path_x2),
    .path_y   (path_y2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Maze memories: combinational read while RD, write on the rising edge.
  assign bus.D_out  = bus.RD  ? mem[{bus.Y, bus.X}]   : 1'b0;
  assign bus2.D_out = bus2.RD ? mem2[{bus2.Y, bus2.X}] : 1'b0;

  always @(posedge clk) begin
    if (bus.WR) mem[{bus.Y, bus.X}] <= bus.D_in;
    if (bus2.WR) mem2[{bus2.Y, bus2.X}] <= bus2.D_in;
  end

  // Bus protocol watch: never read and write together, D_in tracks WR.
  always @(negedge clk) begin
    if (bus.RD && bus.WR) overlap_cnt <= overlap_cnt + 1;
    if (bus.D_in != bus.WR) din_bad_cnt <= din_bad_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic fill_maze(input logic val);
    for (int i = 0; i < 256; i++) mem[i] = val;
  endtask

  task automatic set_cell(input int x, input int y, input logic val);
    mem[y * 16 + x] = val;
  endtask

  // Start a search and follow it to completion, counting busy/RD/WR cycles.
  // A start pulse is also injected while busy when pulse_at >= 0.
  task automatic do_search(input int pulse_at, output int busy_cyc,
                           output int rd_cyc, output int wr_cyc,
                           output bit timed_out);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    busy_cyc  = 0;
    rd_cyc    = 0;
    wr_cyc    = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (busy) busy_cyc++;
      if (bus.RD) rd_cyc++;
      if (bus.WR) wr_cyc++;
      if (done || fail) begin
        timed_out = 1'b0;
        break;
      end
      start = (i == pulse_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic check_path(input string tag, input int idx, input int ex,
                            input int ey);
    path_idx = idx[7:0];
    #1;
    check({tag, "_x"}, 32'(path_x), ex[31:0]);
    check({tag, "_y"}, 32'(path_y), ey[31:0]);
  endtask

  int  bc, rc, wc;
  bit  to;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    overlap_cnt = 0;
    din_bad_cnt = 0;
    start       = 1'b0;
    start2      = 1'b0;
    path_idx    = 8'd0;
    path_idx2   = 8'd0;
    rst_n       = 1'b0;
    fill_maze(1'b0);
    for (int i = 0; i < 256; i++) mem2[i] = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_len", 32'(path_len), 0);
    check("rst_rd", 32'(bus.RD), 0);
    check("rst_wr", 32'(bus.WR), 0);
    check("rst_xy", 32'({bus.X, bus.Y}), 0);
    rst_n = 1'b1;

    // Open maze, default corners; a start pulse mid-search must be ignored
    do_search(10, bc, rc, wc, to);
    $display("open maze: busy=%0d len=%0d done=%0d", bc, path_len, done);
    check("open_timeout", 32'(to), 0);
    check("open_busy", bc, 77);
    check("open_done", 32'(done), 1);
    check("open_len", 32'(path_len), 31);
    check_path("open_p0", 0, 0, 0);
    check_path("open_p15", 15, 15, 0);
    check_path("open_p30", 30, 15, 15);

    // Blocked start cell
    fill_maze(1'b0);
    set_cell(0, 0, 1'b1);
    do_search(-1, bc, rc, wc, to);
    $display("blocked start: busy=%0d wr=%0d fail=%0d", bc, wc, fail);
    check("blk_timeout", 32'(to), 0);
    check("blk_busy", bc, 1);
    check("blk_fail", 32'(fail), 1);
    check("blk_done", 32'(done), 0);
    check("blk_wr", wc, 0);
    check("blk_len", 32'(path_len), 0);

    // Dead end: both in-range neighbors of the start are walls
    fill_maze(1'b0);
    set_cell(1, 0, 1'b1);
    set_cell(0, 1, 1'b1);
    do_search(-1, bc, rc, wc, to);
    $display("dead end: busy=%0d rd=%0d wr=%0d fail=%0d", bc, rc, wc, fail);
    check("dead_timeout", 32'(to), 0);
    check("dead_busy", bc, 7);
    check("dead_rd", rc, 3);
    check("dead_wr", wc, 1);
    check("dead_fail", 32'(fail), 1);
    check("dead_mark", 32'(mem[0]), 1);

    // Backtracking: (1,0) is a dead end, the path goes down column 0
    fill_maze(1'b1);
    set_cell(0, 0, 1'b0);
    set_cell(1, 0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      set_cell(0, i, 1'b0);
      set_cell(i, 15, 1'b0);
    end
    do_search(-1, bc, rc, wc, to);
    $display("backtrack: busy=%0d len=%0d done=%0d", bc, path_len, done);
    check("bt_timeout", 32'(to), 0);
    check("bt_done", 32'(done), 1);
    check("bt_len", 32'(path_len), 31);
    check_path("bt_p1", 1, 0, 1);
    check_path("bt_p16", 16, 1, 15);
    check("bt_mark", 32'(mem[1]), 1);

    // Reset in the middle of a search
    fill_maze(1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("mid-search reset: busy=%0d rd=%0d wr=%0d", busy, bus.RD, bus.WR);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_rd", 32'(bus.RD), 0);
    check("mrst_wr", 32'(bus.WR), 0);
    check("mrst_xy", 32'({bus.X, bus.Y}), 0);
    @(posedge clk); #1;
    check("mrst_rd_hold", 32'(bus.RD), 0);
    rst_n = 1'b1;
    fill_maze(1'b0);
    do_search(-1, bc, rc, wc, to);
    $display("after reset: busy=%0d len=%0d done=%0d", bc, path_len, done);
    check("rerun_timeout", 32'(to), 0);
    check("rerun_busy", bc, 77);
    check("rerun_len", 32'(path_len), 31);
    check("rerun_done", 32'(done), 1);

    check("bus_overlap", overlap_cnt, 0);
    check("bus_din", din_bad_cnt, 0);

    // Start equal to goal on the second instance
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    bc = 0;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (busy2) bc++;
      if (done2 || fail2) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    path_idx2 = 8'd0;
    #1;
    $display("start==goal: busy=%0d len=%0d done=%0d", bc, path_len2, done2);
    check("sg_timeout", 32'(to), 0);
    check("sg_busy", bc, 2);
    check("sg_done", 32'(done2), 1);
    check("sg_len", 32'(path_len2), 1);
    check("sg_xy", 32'({path_x2, path_y2}), 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/maze_solver.md
# maze_solver

Depth-first maze solver that acts as the initiator on the 16x16 maze memory bus. It drives X/Y/RD/WR/D_in and samples the memory's combinational D_out to search from a start cell to a goal cell. It marks visited cells by writing 1 into the maze, and keeps the current path on an internal 256-entry stack. After a successful search, the path can be read back by index.

## Interface
- START_X, 0: start column (4 bits).
- START_Y, 0: start row (4 bits).
- GOAL_X, 15: goal column (4 bits).
- GOAL_Y, 15: goal row (4 bits).

Ports:
- clk, in, 1: single clock; all state changes on rising edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- start, in, 1: begin search; sampled only in IDLE, DONE and FAIL.
- X, out, 4: memory column address.
- Y, out, 4: memory row address.
- RD, out, 1: memory read strobe.
- WR, out, 1: memory write strobe; memory writes on the rising edge.
- D_in, out, 1: memory write data; always 1 when WR=1, else 0.
- D_out, in, 1: memory read data, valid in the same cycle as RD; 1 = wall or visited.
- busy, out, 1: search in progress.
- done, out, 1: goal reached; held until the next start.
- fail, out, 1: no path exists; held until the next start.
- path_len, out, 9: number of cells on the found path, 1..256; 0 unless done.
- path_idx, in, 8: path readout index; 0 = start cell.
- path_x, out, 4: column of stack[path_idx], combinational.
- path_y, out, 4: row of stack[path_idx], combinational.

## Operation
- **State:** cur (x,y), dir (2 bits), stack[256] of {x,y}, sp (9 bits).
- **Neighbor order:** dir 0 = right (x+1), 1 = down (y+1), 2 = left (x-1), 3 = up (y-1).
- **IDLE:**
  - Outputs are idle: X=Y=0, RD=WR=0.
  - On start: cur<=START, sp<=0, go to INIT.
- **INIT:**
  - Drive RD=1 at cur.
  - D_out=1 (start cell blocked): go to FAIL.
  - D_out=0: go to MARK.
- **MARK:**
  - Drive WR=1, D_in=1 at cur.
  - Push: stack[sp]<=cur, sp<=sp+1.
  - If cur==GOAL, go to DONE; else dir<=0 and go to CHECK.
- **CHECK:** one cycle per direction.
  - If the neighbor falls outside 0..15, keep RD=0 and treat the neighbor as blocked. The address must never wrap.
  - Otherwise drive RD=1 at the neighbor and sample D_out.
  - Free neighbor (D_out=0): cur<=neighbor, go to MARK.
  - Blocked and dir<3: dir<=dir+1, stay in CHECK.
  - Blocked and dir==3: go to BACKTRACK.
- **BACKTRACK:**
  - If sp==1: go to FAIL.
  - Otherwise: sp<=sp-1, cur<=stack[sp-2], dir<=0, go to CHECK. Already-marked cells read as 1, so restarting at dir 0 is correct.
- **DONE:** done=1, busy=0, path_len=sp.
- **FAIL:** fail=1, busy=0, path_len=0.
- **Restart:** start in DONE or FAIL re-enters INIT, clearing done, fail and path_len. Visited marks remain in the memory; reloading the maze is the environment's job.
- **Stack bound:** each cell is pushed at most once, so 256 entries cannot overflow. A check on sp is not required.
- **path_x/path_y:** undefined for path_idx >= path_len.

## Timing
- **Reset values:** state=IDLE, cur=0, dir=0, sp=0; X=Y=0, RD=WR=D_in=0, busy=done=fail=0, path_len=0.
- **Reset mid-search:** returns to IDLE immediately; no further memory access. Marks already written stay in the memory.
- **busy:** high in INIT, MARK, CHECK and BACKTRACK.
- **Memory access:** at most one per cycle; RD and WR are never high together.
- **start while busy:** ignored.
- **Per-move cost:** 1 MARK cycle, plus 1 CHECK cycle for each direction tried, plus 1 cycle per BACKTRACK.
- **start==goal:** INIT, MARK, DONE; busy for 2 cycles, path_len=1.

## Test plan
- **All-zero maze, defaults:**
  - Path runs along row 0, then down column 15.
  - path_len=31, busy for exactly 77 cycles, done=1.
  - path_idx=15 gives (15,0); path_idx=30 gives (15,15).
- **Blocked start:** cell (0,0)=1 → fail=1 after a 1-cycle busy; WR never asserted.
- **Dead end:** (1,0)=(0,1)=1.
  - Sequence: INIT, MARK, 4 CHECK cycles (only 2 with RD=1), BACKTRACK, then fail=1.
  - Memory (0,0) reads 1 afterwards.
- **Backtracking:** free cells are (0,0), (1,0), column 0 and row 15; all others are walls.
  - Search enters (1,0), backtracks, and completes.
  - path_len=31; path_idx=1 gives (0,1); memory (1,0) reads 1.
- **Reset and restart:**
  - Pulse rst_n low mid-search → all outputs return to reset values within the same cycle.
  - Reload the maze, then start → same result as the all-zero test.
- **Start handling:**
  - Pulse start while busy → no effect.
  - START=GOAL=(5,5) on an open maze → done with path_len=1.
